cache_refill_arbiter: RTL and testbench
=======================================

// Module: cache_refill_arbiter
// PURPOSE
//  Shares one AXI4 master port between the I-cache (requester 0) and the D-cache (requester 1).
//  Each requester posts whole-line refill (read) or writeback (write) requests on a simple valid/ready interface.
//  The block arbitrates round-robin, issues one INCR burst per line, and returns the line plus an error flag.
//  Sits between the cache controllers and the memory-side AXI port; one transaction in flight at a time.
// PARAMETERS
//  AddrWidth  32   AXI/request address width
//  DataWidth  32   AXI data width; beat = DataWidth/8 bytes
//  LineWidth  128  cache line width; Beats = LineWidth/DataWidth (power of 2, 1..16)
//  IdWidth    4    AXI ID width; ID = requester index, zero-extended
// PORTS
//  clk_i                       in   1          clock
//  rst_ni                      in   1          async active-low reset
//  req_valid_i / req_ready_o   in/out [1:0]    per-requester request handshake
//  req_we_i                    in   [1:0]      1 = writeback, 0 = refill
//  req_addr_i                  in   [1:0][AW]  line address; low log2(LineWidth/8) bits ignored (forced 0)
//  req_wdata_i                 in   [1:0][LW]  writeback line; word 0 = lowest address
//  rsp_valid_o                 out  [1:0]      one-cycle completion pulse to owning requester
//  rsp_rdata_o                 out  LW         refill line (valid with rsp_valid_o)
//  rsp_err_o                   out  1          any RRESP/BRESP != OKAY or beat-count mismatch
//  m_ar{id,addr,len,size,burst,valid}_o, m_arready_i                 AXI AR channel
//  m_r{id,data,resp,last,valid}_i, m_rready_o                        AXI R channel
//  m_aw{id,addr,len,size,burst,valid}_o, m_awready_i                 AXI AW channel
//  m_w{data,strb,last,valid}_o, m_wready_i                           AXI W channel
//  m_b{id,resp,valid}_i, m_bready_o                                  AXI B channel
// BEHAVIOUR
//  Reset: all valid/ready outputs 0, data outputs 0, FSM=IDLE, rr pointer=0 (requester 0 preferred first).
//  FSM: IDLE -> AR -> RDAT -> RESP -> IDLE (read); IDLE -> AW -> WDAT -> BRSP -> RESP -> IDLE (write).
//  IDLE: if any req_valid_i, grant per rr pointer (the pointed requester wins ties, else the only valid one).
//    Assert req_ready_o[g] combinationally in IDLE for exactly the accept cycle.
//    Capture addr (line-aligned), we, wdata. Pointer <- ~g after each grant.
//  Requesters hold req_valid_i and payload until ready; a deasserted valid before grant is dropped silently.
//  AR/AW: valid asserted the cycle after grant.
//    Held with stable payload until ready. len=Beats-1, size=log2(DataWidth/8), burst=INCR(2'b01), id=g.
//  RDAT: m_rready_o=1; each beat stores rdata into word[cnt], cnt++.
//    Ends on rlast; if rlast arrives at cnt!=Beats-1, or cnt reaches Beats without rlast, set err.
//    On overrun, keep consuming until rlast, discarding extra beats.
//  WDAT: m_wvalid_o=1 with word[cnt], strb all-ones, wlast when cnt==Beats-1; advance on wready.
//  BRSP: m_bready_o=1 until bvalid; BRESP[1]=1 sets err.
//  RESP: rsp_valid_o[g]=1 for one cycle with rdata/err; err cleared on the next grant.
//    Next grant possible the cycle after RESP (no back-to-back in RESP).
//  Any RRESP[1]=1 sets err (sticky for the transaction). Mismatched rid/bid is ignored; only one ID is outstanding.
//  Min latency (zero-wait slave): read = 1 (AR) + Beats + 1 (RESP) cycles after accept; write = 1 + Beats + 1 + 1.
//  Async reset mid-transaction returns to IDLE and drops valids; no response is issued (system reset assumed global).
//  AXI rule: no valid depends combinationally on ready; ready outputs may depend on state only.
// STRUCTURE
//  Package cache_arb_pkg: state enum arb_state_e, AXI_BURST_INCR, AXI_RESP_OKAY, line/beat helper functions.
//  Sub-module rr_arb2 (2-way round-robin grant + pointer register); FSM, beat counter, and line buffer in top.
// TESTING
//  1. Lone refill: req0 addr 0x1004, slave data 0xA0..0xA3 -> araddr 0x1000, arlen 3, arid 0; rsp_valid[0] rdata {A3,A2,A1,A0}, err 0.
//  2. Simultaneous req0 read + req1 write after reset -> req0 granted first, req1 next; rsp order 0 then 1.
//  3. Writeback: req1 wdata 0xDDCCBBAA_.. with wready stalled 3 cycles on beat 2 -> wdata/wlast stable, wlast on beat 3, bid 1.
//  4. RRESP=SLVERR on beat 1 -> all 4 beats consumed; rsp_err_o=1; next transaction err=0.
//  5. Early rlast at beat 2 of 4 -> transaction ends, rsp_err_o=1, FSM back in IDLE; next request serviced normally.
//  6. rst_ni low during RDAT -> all outputs 0 asynchronously; after release, a new request completes correctly.

Source files
------------

// File: rtl/cache_refill_arbiter_pkg.sv
// Shared types, constants and helpers for the cache refill arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_arb_pkg;

    // FSM encoding kept as plain vectors so legacy tools and waveform scripts see stable codes.
    typedef logic [2:0] arb_state_e;
    localparam arb_state_e ST_IDLE = 3'd0;
    localparam arb_state_e ST_AR   = 3'd1;
    localparam arb_state_e ST_RDAT = 3'd2;
    localparam arb_state_e ST_AW   = 3'd3;
    localparam arb_state_e ST_WDAT = 3'd4;
    localparam arb_state_e ST_BRSP = 3'd5;
    localparam arb_state_e ST_RESP = 3'd6;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Number of AXI data beats that make up one cache line.
    function automatic int line_beats(input int line_w, input int data_w);
        return line_w / data_w;
    endfunction

    // AXI AxSIZE encoding for a full-width beat.
    function automatic int beat_size(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// AXI4 master-side bundle (AR/R/AW/W/B) between the refill arbiter and memory.
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready on every channel.
interface cache_refill_arbiter_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 4
);
    logic [IdWidth-1:0]     arid;
    logic [AddrWidth-1:0]   araddr;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   arvalid;
    logic                   arready;

    logic [IdWidth-1:0]     rid;
    logic [DataWidth-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;

    logic [IdWidth-1:0]     awid;
    logic [AddrWidth-1:0]   awaddr;
    logic [7:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic                   awvalid;
    logic                   awready;

    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   wlast;
    logic                   wvalid;
    logic                   wready;

    logic [IdWidth-1:0]     bid;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready
    );
endinterface

// File: rtl/cache_refill_arbiter_rr_arb2.sv
// Two-way round-robin grant with pointer register; pointer moves to the loser after each grant.
// Latency: grant is combinational in the take cycle; pointer updates on the following edge.
// Backpressure: no grant while take_i is low; requests simply wait.
// Ports: clk_i/rst_ni, req_i (per-requester valid), take_i (arbiter may accept now),
//        gnt_o (one-hot accept), idx_o (index of the requester that would win).
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        // Pointed requester wins ties; otherwise the other one (if it is valid at all).
        idx_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
        if (take_i && (req_i != 2'b00)) begin
            gnt_o[idx_o] = 1'b1;
            ptr_d        = ~idx_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one AXI4 master between I-cache (0) and D-cache (1): whole-line refills and writebacks.
// Latency: read = 1 + Beats + 1 cycles after accept, write = 1 + Beats + 1 + 1 (zero-wait slave).
// Backpressure: one transaction in flight; req_ready_o only pulses in IDLE; AXI stalls hold payload.
// Ports: clk_i/rst_ni; req_{valid,ready,we,addr,wdata} per requester; rsp_{valid,rdata,err};
//        m_axi carries the AR/R/AW/W/B channels.
module cache_refill_arbiter
    import cache_arb_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int LineWidth = 128,
    parameter int IdWidth   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [1:0]                req_valid_i,
    output logic [1:0]                req_ready_o,
    input  logic [1:0]                req_we_i,
    input  logic [1:0][AddrWidth-1:0] req_addr_i,
    input  logic [1:0][LineWidth-1:0] req_wdata_i,
    output logic [1:0]                rsp_valid_o,
    output logic [LineWidth-1:0]      rsp_rdata_o,
    output logic                      rsp_err_o,
    cache_refill_arbiter_if.master    m_axi
);
    localparam int Beats = line_beats(LineWidth, DataWidth);
    localparam int CntW  = $clog2(Beats + 1);
    localparam int OffW  = $clog2(LineWidth / 8);
    localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Beats);

    arb_state_e           state_q, state_d;
    logic                 gnt_q, gnt_d;
    logic                 we_q, we_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [LineWidth-1:0] line_q, line_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic [1:0]           gnt;
    logic                 gnt_idx;
    logic [DataWidth-1:0] cur_word;
    logic                 in_ar, in_rdat, in_aw, in_wdat, in_brsp, in_resp;
    logic                 unused_sink;

    // Reset gates the take so req_ready_o stays low while rst_ni is asserted.
    rr_arb2 u_rr_arb2 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_valid_i),
        .take_i (rst_ni && (state_q == ST_IDLE)),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    assign req_ready_o = gnt;

    assign in_ar   = (state_q == ST_AR);
    assign in_rdat = (state_q == ST_RDAT);
    assign in_aw   = (state_q == ST_AW);
    assign in_wdat = (state_q == ST_WDAT);
    assign in_brsp = (state_q == ST_BRSP);
    assign in_resp = (state_q == ST_RESP);

    always_comb begin
        cur_word = '0;
        for (int i = 0; i < Beats; i++) begin
            if (cnt_q == CntW'(i)) cur_word = line_q[i*DataWidth +: DataWidth];
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    gnt_d   = gnt_idx;
                    we_d    = req_we_i[gnt_idx];
                    addr_d  = {req_addr_i[gnt_idx][AddrWidth-1:OffW], {OffW{1'b0}}};
                    // Refills start from a zeroed buffer so short bursts leave defined words.
                    line_d  = req_we_i[gnt_idx] ? req_wdata_i[gnt_idx] : '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = req_we_i[gnt_idx] ? ST_AW : ST_AR;
                end
            end
            ST_AR: if (m_axi.arready) state_d = ST_RDAT;
            ST_RDAT: begin
                if (m_axi.rvalid) begin
                    if (m_axi.rresp[1]) err_d = 1'b1;
                    // Beats past the end of the line (cnt == Beats) match no word and are dropped.
                    for (int i = 0; i < Beats; i++) begin
                        if (cnt_q == CntW'(i)) line_d[i*DataWidth +: DataWidth] = m_axi.rdata;
                    end
                    if (m_axi.rlast) begin
                        if (cnt_q != LastCnt) err_d = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        if (cnt_q == LastCnt) err_d = 1'b1;
                        if (cnt_q != FullCnt) cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_AW: if (m_axi.awready) state_d = ST_WDAT;
            ST_WDAT: begin
                if (m_axi.wready) begin
                    if (cnt_q == LastCnt) state_d = ST_BRSP;
                    else                  cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_BRSP: begin
                if (m_axi.bvalid) begin
                    if (m_axi.bresp[1]) err_d = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Payloads are zero whenever their valid is low; all driven from registered state only.
    assign m_axi.arvalid = in_ar;
    assign m_axi.arid    = in_ar ? IdWidth'(gnt_q) : '0;
    assign m_axi.araddr  = in_ar ? addr_q : '0;
    assign m_axi.arlen   = in_ar ? 8'(Beats - 1) : '0;
    assign m_axi.arsize  = in_ar ? 3'(beat_size(DataWidth)) : '0;
    assign m_axi.arburst = in_ar ? AXI_BURST_INCR : AXI_RESP_OKAY;
    assign m_axi.rready  = in_rdat;

    assign m_axi.awvalid = in_aw;
    assign m_axi.awid    = in_aw ? IdWidth'(gnt_q) : '0;
    assign m_axi.awaddr  = in_aw ? addr_q : '0;
    assign m_axi.awlen   = in_aw ? 8'(Beats - 1) : '0;
    assign m_axi.awsize  = in_aw ? 3'(beat_size(DataWidth)) : '0;
    assign m_axi.awburst = in_aw ? AXI_BURST_INCR : AXI_RESP_OKAY;

    assign m_axi.wvalid  = in_wdat;
    assign m_axi.wdata   = in_wdat ? cur_word : '0;
    assign m_axi.wstrb   = in_wdat ? '1 : '0;
    assign m_axi.wlast   = in_wdat && (cnt_q == LastCnt);
    assign m_axi.bready  = in_brsp;

    assign rsp_valid_o = in_resp ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata_o = (in_resp && !we_q) ? line_q : '0;
    assign rsp_err_o   = in_resp && err_q;

    // Only one ID is ever outstanding, so rid/bid carry no information here.
    assign unused_sink = ^{m_axi.rid, m_axi.bid, m_axi.rresp[0], m_axi.bresp[0],
                           req_addr_i[0][OffW-1:0], req_addr_i[1][OffW-1:0]};
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Scoreboard bench: expected AR/AW/W/response items are queued at stimulus time, a monitor pops them.
// Latency: n/a.
// Backpressure: slave model stalls W on a chosen beat; AR/AW always ready.
module tb_cache_refill_arbiter;
    localparam int AW = 32, DW = 32, LW = 128, IW = 4;

    typedef struct { int idx; logic [LW-1:0] rdata; logic err; } rsp_t;
    typedef struct { logic [AW-1:0] addr; logic [IW-1:0] id; } ax_t;
    typedef struct { logic [DW-1:0] d; logic [1:0] resp; logic last; } rbeat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          req_valid, req_ready, req_we, rsp_valid;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0][LW-1:0]  req_wdata;
    logic [LW-1:0]       rsp_rdata;
    logic                rsp_err;

    cache_refill_arbiter_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) axi ();

    cache_refill_arbiter #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW), .IdWidth(IW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .m_axi(axi)
    );

    rsp_t           exp_rsp[$];
    ax_t            exp_ar[$], exp_aw[$];
    logic [DW:0]    exp_w[$];   // bit DW = expected wlast
    rbeat_t         rq[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic missing(input string name);
        tests++;
        fails++;
        $display("FAIL %s: DUT output seen but nothing expected", name);
    endtask

    // ---------------- monitor ----------------
    rsp_t        me;
    ax_t         ma;
    logic [DW:0] mw;
    logic [1:0]  mv;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rsp_valid != 2'b00) begin
                    if (exp_rsp.size() == 0) missing("rsp");
                    else begin
                        me = exp_rsp.pop_front();
                        mv = (me.idx == 1) ? 2'b10 : 2'b01;
                        chk("rsp_valid", LW'(rsp_valid), LW'(mv));
                        chk("rsp_rdata", rsp_rdata, me.rdata);
                        chk("rsp_err", LW'(rsp_err), LW'(me.err));
                    end
                end
                if (axi.arvalid && axi.arready) begin
                    if (exp_ar.size() == 0) missing("ar");
                    else begin
                        ma = exp_ar.pop_front();
                        chk("araddr", LW'(axi.araddr), LW'(ma.addr));
                        chk("arid", LW'(axi.arid), LW'(ma.id));
                        chk("arlen", LW'(axi.arlen), LW'(8'd3));
                        chk("arsize_burst", LW'({axi.arsize, axi.arburst}), LW'(5'b010_01));
                    end
                end
                if (axi.awvalid && axi.awready) begin
                    if (exp_aw.size() == 0) missing("aw");
                    else begin
                        ma = exp_aw.pop_front();
                        chk("awaddr", LW'(axi.awaddr), LW'(ma.addr));
                        chk("awid", LW'(axi.awid), LW'(ma.id));
                        chk("awlen", LW'(axi.awlen), LW'(8'd3));
                        chk("awsize_burst", LW'({axi.awsize, axi.awburst}), LW'(5'b010_01));
                    end
                end
                // Checked every valid cycle, so stalled beats must hold data and wlast.
                if (axi.wvalid) begin
                    if (exp_w.size() == 0) missing("w");
                    else begin
                        mw = exp_w[0];
                        chk("wdata", LW'(axi.wdata), LW'(mw[DW-1:0]));
                        chk("wlast", LW'(axi.wlast), LW'(mw[DW]));
                        chk("wstrb", LW'(axi.wstrb), LW'(4'hF));
                        if (axi.wready) exp_w.delete(0);
                    end
                end
            end
        end
    end

    // ---------------- slave + requester environment ----------------
    logic       ar_hs, r_hs, aw_hs, w_hs, wl_hs, b_hs, r_armed, b_pend;
    logic [1:0] acc;
    logic [IW-1:0] ar_id_s, aw_id_s, r_id, b_id;
    int w_cnt = 0, stall_beat = 0, w_stall = 0;
    initial begin
        r_armed = 1'b0; b_pend = 1'b0; r_id = '0; b_id = '0;
        axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
        axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rid = '0;
        axi.bvalid = 1'b0; axi.bresp = '0; axi.bid = '0;
        forever begin
            @(negedge clk);
            ar_hs = axi.arvalid && axi.arready;  ar_id_s = axi.arid;
            aw_hs = axi.awvalid && axi.awready;  aw_id_s = axi.awid;
            r_hs  = axi.rvalid && axi.rready;
            w_hs  = axi.wvalid && axi.wready;
            wl_hs = w_hs && axi.wlast;
            b_hs  = axi.bvalid && axi.bready;
            acc   = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) if (acc[i]) req_valid[i] = 1'b0;
            if (r_hs && rq.size() > 0) rq.delete(0);
            if (ar_hs) begin r_armed = 1'b1; r_id = ar_id_s; end
            if (aw_hs) begin w_cnt = 0; b_id = aw_id_s; end
            if (w_hs) w_cnt++;
            if (wl_hs) b_pend = 1'b1;
            if (b_hs) b_pend = 1'b0;
            if (r_armed && rq.size() > 0) begin
                axi.rvalid = 1'b1; axi.rdata = rq[0].d; axi.rresp = rq[0].resp;
                axi.rlast = rq[0].last; axi.rid = r_id;
            end else begin
                axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
                r_armed = 1'b0;
            end
            if (w_stall > 0 && w_cnt == stall_beat) begin
                axi.wready = 1'b0;
                w_stall--;
            end else begin
                axi.wready = 1'b1;
            end
            axi.bvalid = b_pend; axi.bid = b_id; axi.bresp = 2'b00;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic post(input int idx, input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] wd);
        req_valid[idx] = 1'b1; req_we[idx] = we; req_addr[idx] = addr; req_wdata[idx] = wd;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [1:0] resp, input logic last);
        rq.push_back('{d, resp, last});
    endtask

    task automatic line4(input logic [DW-1:0] base);
        for (int i = 0; i < 4; i++) beat(base + DW'(i), 2'b00, (i == 3));
    endtask

    task automatic exp_write(input logic [LW-1:0] wd);
        for (int i = 0; i < 4; i++) exp_w.push_back({(i == 3), wd[i*DW +: DW]});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_rsp.size() + exp_ar.size() + exp_aw.size() + exp_w.size()) != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (n >= 300) begin
            fails++;
            $display("FAIL %s_timeout: %0d items still pending, required 0", name,
                     exp_rsp.size() + exp_ar.size() + exp_aw.size() + exp_w.size());
            exp_rsp.delete(); exp_ar.delete(); exp_aw.delete(); exp_w.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rq.delete(); r_armed = 1'b0; b_pend = 1'b0; w_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        // Reset state: requests pending during reset must see no ready.
        req_valid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", LW'(req_ready), '0);
        chk("rst_rsp_valid", LW'(rsp_valid), '0);
        chk("rst_rsp_data", rsp_rdata, '0);
        chk("rst_rsp_err", LW'(rsp_err), '0);
        chk("rst_axi_valids", LW'({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}), '0);
        chk("rst_araddr", LW'(axi.araddr), '0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: lone refill, unaligned address.
        beat(32'hA0, 2'b00, 1'b0); beat(32'hA1, 2'b00, 1'b0);
        beat(32'hA2, 2'b00, 1'b0); beat(32'hA3, 2'b00, 1'b1);
        exp_ar.push_back('{32'h1000, 4'd0});
        exp_rsp.push_back('{0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0});
        post(0, 1'b0, 32'h1004, '0);
        wait_done("lone_refill");

        // 2: simultaneous requests after reset: requester 0 first.
        do_reset();
        line4(32'hB0);
        exp_ar.push_back('{32'h2000, 4'd0});
        exp_aw.push_back('{32'h3010, 4'd1});
        exp_write(128'h13131313_12121212_11111111_10101010);
        exp_rsp.push_back('{0, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0});
        exp_rsp.push_back('{1, '0, 1'b0});
        post(0, 1'b0, 32'h2000, '0);
        post(1, 1'b1, 32'h301C, 128'h13131313_12121212_11111111_10101010);
        wait_done("simultaneous");

        // 3: writeback with wready stalled three cycles on beat 2.
        stall_beat = 2; w_stall = 3;
        exp_aw.push_back('{32'h4000, 4'd1});
        exp_write(128'hDDCCBBAA_99887766_55443322_11223344);
        exp_rsp.push_back('{1, '0, 1'b0});
        post(1, 1'b1, 32'h4008, 128'hDDCCBBAA_99887766_55443322_11223344);
        wait_done("writeback_stall");

        // 4: SLVERR on beat 1, all beats still consumed.
        beat(32'hC0, 2'b00, 1'b0); beat(32'hC1, 2'b10, 1'b0);
        beat(32'hC2, 2'b00, 1'b0); beat(32'hC3, 2'b00, 1'b1);
        exp_ar.push_back('{32'h5000, 4'd0});
        exp_rsp.push_back('{0, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1'b1});
        post(0, 1'b0, 32'h5000, '0);
        wait_done("slverr");
        tests++;
        if (rq.size() != 0) begin
            fails++;
            $display("FAIL slverr_beats: actual %0d beats left required 0", rq.size());
        end

        // 4b: following transaction has a clean error flag.
        line4(32'hD0);
        exp_ar.push_back('{32'h6000, 4'd1});
        exp_rsp.push_back('{1, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b0});
        post(1, 1'b0, 32'h6000, '0);
        wait_done("err_cleared");

        // 5: early rlast on beat 2 of 4.
        beat(32'hE0, 2'b00, 1'b0); beat(32'hE1, 2'b00, 1'b0); beat(32'hE2, 2'b00, 1'b1);
        exp_ar.push_back('{32'h7000, 4'd0});
        exp_rsp.push_back('{0, {32'h0, 32'hE2, 32'hE1, 32'hE0}, 1'b1});
        post(0, 1'b0, 32'h7000, '0);
        wait_done("early_rlast");

        // 5b: overrun, rlast only on a fifth beat which is discarded.
        line4(32'hF0);
        rq[3].last = 1'b0;
        beat(32'hF4, 2'b00, 1'b1);
        exp_ar.push_back('{32'h8000, 4'd1});
        exp_rsp.push_back('{1, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 1'b1});
        post(1, 1'b0, 32'h8000, '0);
        wait_done("overrun");

        // 6: asynchronous reset during RDAT, then a clean refill.
        line4(32'h60);
        exp_ar.push_back('{32'h9000, 4'd0});
        post(0, 1'b0, 32'h9000, '0);
        begin
            int n = 0;
            @(negedge clk);
            while (!axi.rready && n < 50) begin @(negedge clk); n++; end
            chk("rdat_reached", LW'(axi.rready), LW'(1'b1));
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_rready", LW'(axi.rready), '0);
        chk("arst_valids", LW'({rsp_valid, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready}), '0);
        chk("arst_req_ready", LW'(req_ready), '0);
        rq.delete(); r_armed = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        line4(32'h70);
        exp_ar.push_back('{32'h9100, 4'd1});
        exp_rsp.push_back('{1, {32'h73, 32'h72, 32'h71, 32'h70}, 1'b0});
        post(1, 1'b0, 32'h9104, '0);
        wait_done("after_arst");

        chk("leftover_rsp", LW'(exp_rsp.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
